// File: rtl/gfx_rom_arb_if.sv
// gfx_rom_arb_if: bundles the three renderer fetch clients and the external
// graphics-ROM read port that gfx_rom_arb sits between.
//   slave  : arbiter side (takes requests and ROM data, returns bytes and ROM strobes)
//   master : environment side (renderer clients and ROM model)
interface gfx_rom_arb_if #(
    parameter int AW = 22
);
    // background tile client
    logic [16:0]   bg_addr;
    logic          bg_req;
    logic [7:0]    bg_data;
    logic          bg_rdy;
    // text tile client
    logic [13:0]   tx_addr;
    logic          tx_req;
    logic [7:0]    tx_data;
    logic          tx_rdy;
    // sprite graphics client
    logic [15:0]   sp_addr;
    logic          sp_req;
    logic [7:0]    sp_data;
    logic          sp_rdy;
    // external ROM read port
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_valid;
    // status
    logic          busy;

    modport slave (
        input  bg_addr, bg_req, tx_addr, tx_req, sp_addr, sp_req, rom_data, rom_valid,
        output bg_data, bg_rdy, tx_data, tx_rdy, sp_data, sp_rdy, rom_addr, rom_cs, busy
    );

    modport master (
        output bg_addr, bg_req, tx_addr, tx_req, sp_addr, sp_req, rom_data, rom_valid,
        input  bg_data, bg_rdy, tx_data, tx_rdy, sp_data, sp_rdy, rom_addr, rom_cs, busy
    );
endinterface

// File: rtl/gfx_rom_arb.sv
// gfx_rom_arb: round-robin sharing of one graphics-ROM read port between the
// background, text and sprite fetch clients (index 0, 1, 2 respectively).
// One access at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// Optional feature macro: GFX_ARB_CACHE_EN adds a one-entry per-client cache;
// a hit goes IDLE -> DONE without touching the ROM.
module gfx_rom_arb #(
    parameter int            AW      = 22,
    parameter logic [AW-1:0] BG_BASE = 22'h000000,
    parameter logic [AW-1:0] TX_BASE = 22'h020000,
    parameter logic [AW-1:0] SP_BASE = 22'h024000
) (
    input  logic         clk,
    input  logic         reset,
    gfx_rom_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_r;
    logic [1:0]    rr_r;          // client checked first at the next arbitration
    logic [1:0]    gnt_r;         // client owning the current access
    logic [AW-1:0] rom_addr_r;
    logic          rom_cs_r;
    logic          busy_r;
    logic [2:0]    rdy_r;
    logic [7:0]    data_r  [3];   // last byte returned per client
    logic [1:0]    blank_r [3];   // per-client re-request blanking

    logic [2:0]    req_s;
    logic [2:0]    elig_s;
    logic [2:0]    pick_s;        // {found, index}
    logic [2:0]    pick_sel_s;
    logic [2:0]    gnt_sel_s;
    logic [AW-1:0] cand_addr_s;

    // Client index to one-hot select.
    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Round-robin successor bg -> tx -> sp -> bg.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // First eligible client searching upward from ptr; returns {found, index}.
    function automatic logic [2:0] pick(input logic [2:0] elig, input logic [1:0] ptr);
        logic [2:0] rot;
        logic [2:0] sum;
        logic [1:0] off;
        case (ptr)
            2'd1:    rot = {elig[0], elig[2], elig[1]};
            2'd2:    rot = {elig[1], elig[0], elig[2]};
            default: rot = elig;
        endcase
        if (rot[0]) begin
            off = 2'd0;
        end else if (rot[1]) begin
            off = 2'd1;
        end else begin
            off = 2'd2;
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end else begin
            sum = sum;
        end
        return {|rot, sum[1:0]};
    endfunction

    // Eligibility, round-robin choice and the candidate's ROM address.
    always_comb begin
        req_s  = {bus.sp_req, bus.tx_req, bus.bg_req};
        elig_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (req_s[i] && (blank_r[i] == 2'd0)) begin
                elig_s[i] = 1'b1;
            end else begin
                elig_s[i] = 1'b0;
            end
        end
        pick_s     = pick(elig_s, rr_r);
        pick_sel_s = onehot(pick_s[1:0]);
        gnt_sel_s  = onehot(gnt_r);
        case (pick_s[1:0])
            2'd1:    cand_addr_s = TX_BASE + {{(AW-14){1'b0}}, bus.tx_addr};
            2'd2:    cand_addr_s = SP_BASE + {{(AW-16){1'b0}}, bus.sp_addr};
            default: cand_addr_s = BG_BASE + {{(AW-17){1'b0}}, bus.bg_addr};
        endcase
    end

`ifdef GFX_ARB_CACHE_EN
    // data_r already holds each client's last completed byte, so the cache
    // only needs the matching address and a valid flag.
    logic [AW-1:0] cache_addr_r [3];
    logic [2:0]    cache_vld_r;
    logic          hit_s;

    // Hit when the candidate's address matches its own valid cache entry.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (pick_sel_s[i] && cache_vld_r[i] && (cache_addr_r[i] == cand_addr_s)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Refill the granted client's entry on every ROM completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_vld_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cache_addr_r[i] <= '0;
            end
        end else if ((state_r == WAIT) && bus.rom_valid) begin
            for (int i = 0; i < 3; i++) begin
                if (gnt_sel_s[i]) begin
                    cache_vld_r[i]  <= 1'b1;
                    cache_addr_r[i] <= rom_addr_r;
                end
            end
        end
    end
`endif

    // Access sequencer: grant, strobe the ROM, capture data, pulse rdy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            rr_r       <= 2'd0;
            gnt_r      <= 2'd0;
            rom_addr_r <= '0;
            rom_cs_r   <= 1'b0;
            busy_r     <= 1'b0;
            rdy_r      <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                data_r[i] <= 8'h00;
            end
        end else begin
            rdy_r <= 3'b000;
            case (state_r)
                IDLE: begin
                    if (pick_s[2]) begin
                        gnt_r  <= pick_s[1:0];
                        busy_r <= 1'b1;
`ifdef GFX_ARB_CACHE_EN
                        if (hit_s) begin
                            state_r <= DONE;
                        end else begin
                            rom_addr_r <= cand_addr_s;
                            state_r    <= ISSUE;
                        end
`else
                        rom_addr_r <= cand_addr_s;
                        state_r    <= ISSUE;
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    rom_cs_r <= 1'b1;
                    state_r  <= WAIT;
                end
                WAIT: begin
                    if (bus.rom_valid) begin
                        for (int i = 0; i < 3; i++) begin
                            if (gnt_sel_s[i]) begin
                                data_r[i] <= bus.rom_data;
                            end
                        end
                        rom_cs_r <= 1'b0;
                        state_r  <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    rdy_r   <= gnt_sel_s;
                    rr_r    <= next_idx(gnt_r);
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    rom_cs_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Blanking: the client just served is ignored for two cycles so its
    // one-cycle-late req drop cannot trigger a second service.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                blank_r[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if ((state_r == DONE) && gnt_sel_s[i]) begin
                    blank_r[i] <= 2'd2;
                end else if (blank_r[i] != 2'd0) begin
                    blank_r[i] <= blank_r[i] - 2'd1;
                end else begin
                    blank_r[i] <= 2'd0;
                end
            end
        end
    end

    assign bus.rom_addr = rom_addr_r;
    assign bus.rom_cs   = rom_cs_r;
    assign bus.busy     = busy_r;
    assign bus.bg_rdy   = rdy_r[0];
    assign bus.tx_rdy   = rdy_r[1];
    assign bus.sp_rdy   = rdy_r[2];
    assign bus.bg_data  = data_r[0];
    assign bus.tx_data  = data_r[1];
    assign bus.sp_data  = data_r[2];

endmodule

// File: tb/tb_gfx_rom_arb.sv
// tb_gfx_rom_arb: scoreboard bench for gfx_rom_arb. Client drivers push the
// expected byte (a fixed function of the full ROM address) when they raise
// req; a monitor pops and compares on every rdy pulse; a ROM model answers
// rom_cs after a configurable or random delay.
module tb_gfx_rom_arb;
    localparam int          AW      = 22;
    localparam logic [21:0] BG_BASE = 22'h000000;
    localparam logic [21:0] TX_BASE = 22'h020000;
    localparam logic [21:0] SP_BASE = 22'h024000;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    gfx_rom_arb_if #(.AW(AW)) bus ();

    gfx_rom_arb #(.AW(AW), .BG_BASE(BG_BASE), .TX_BASE(TX_BASE), .SP_BASE(SP_BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t exp_q2[$];
    int   rdy_cnt[3];
    int   rdy_cyc[3];
    int   order_q[$];
    logic [21:0] acc_q[$];
    int   acc_cnt = 0;
    int   rom_delay_cfg = 1;   // 0 selects a random delay of 1..4
    bit   rom_silent = 1'b0;
    bit   force_valid = 1'b0;
    int   rom_age = 0;
    int   rom_want = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ROM contents: an arbitrary fixed byte per address.
    function automatic logic [7:0] rom_byte(input logic [21:0] a);
        logic [31:0] t;
        t = ({10'd0, a} * 32'd37) + ({10'd0, a} >> 9);
        return t[7:0];
    endfunction

    function automatic logic [21:0] full_addr(input int id, input logic [16:0] a);
        logic [31:0] s;
        case (id)
            0:       s = {10'd0, BG_BASE} + {15'd0, a};
            1:       s = {10'd0, TX_BASE} + {18'd0, a[13:0]};
            default: s = {10'd0, SP_BASE} + {16'd0, a[15:0]};
        endcase
        return s[21:0];
    endfunction

    function automatic logic get_rdy(input int id);
        case (id)
            0:       return bus.bg_rdy;
            1:       return bus.tx_rdy;
            default: return bus.sp_rdy;
        endcase
    endfunction

    function automatic logic [7:0] get_data(input int id);
        case (id)
            0:       return bus.bg_data;
            1:       return bus.tx_data;
            default: return bus.sp_data;
        endcase
    endfunction

    function automatic bit addr_pending(input logic [21:0] a);
        bit ok;
        ok = 1'b0;
        if (exp_q0.size() > 0 && exp_q0[0].addr == a) ok = 1'b1;
        if (exp_q1.size() > 0 && exp_q1[0].addr == a) ok = 1'b1;
        if (exp_q2.size() > 0 && exp_q2[0].addr == a) ok = 1'b1;
        return ok;
    endfunction

    task automatic push_exp(input int id, input exp_t e);
        case (id)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    task automatic set_req(input int id, input logic v, input logic [16:0] a);
        case (id)
            0:       begin bus.bg_req = v; bus.bg_addr = a;        end
            1:       begin bus.tx_req = v; bus.tx_addr = a[13:0];  end
            default: begin bus.sp_req = v; bus.sp_addr = a[15:0];  end
        endcase
    endtask

    // One renderer-style request served n times; req drops one cycle after the last rdy.
    task automatic client_txn(input int id, input logic [16:0] a, input int n, output int lat);
        exp_t e;
        int   c0;
        int   start;
        @(negedge clk);
        e.addr = full_addr(id, a);
        e.data = rom_byte(e.addr);
        for (int k = 0; k < n; k++) push_exp(id, e);
        c0    = rdy_cnt[id];
        start = cyc;
        set_req(id, 1'b1, a);
        for (int t = 0; t < 300 && rdy_cnt[id] < c0 + n; t++) @(negedge clk);
        if (rdy_cnt[id] < c0 + n) begin
            chk("rdy_timeout", rdy_cnt[id], c0 + n);
            lat = -1;
        end else begin
            lat = rdy_cyc[id] - start;
        end
        @(negedge clk);
        set_req(id, 1'b0, a);
    endtask

    task automatic rand_client(input int id, input int n);
        logic [16:0] a;
        int          lat;
        a = 17'($urandom);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if ($urandom_range(0, 2) != 0) a = 17'($urandom);
            client_txn(id, a, 1, lat);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 17'd0);
        repeat (2) @(negedge clk);
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        acc_q.delete(); order_q.delete();
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ROM model: counts accesses, checks the address, answers after the delay.
    initial begin
        bus.rom_valid = 1'b0;
        bus.rom_data  = 8'h00;
        forever begin
            @(negedge clk);
            bus.rom_valid = 1'b0;
            if (force_valid) begin
                bus.rom_valid = 1'b1;
                bus.rom_data  = 8'hA5;
                force_valid   = 1'b0;
                rom_age       = 0;
            end else if (bus.rom_cs && !reset) begin
                if (rom_age == 0) begin
                    acc_cnt++;
                    acc_q.push_back(bus.rom_addr);
                    chk("rom_addr_legal", {31'd0, addr_pending(bus.rom_addr)}, 32'd1);
                    rom_want = (rom_delay_cfg > 0) ? rom_delay_cfg : int'($urandom_range(1, 4));
                end
                rom_age++;
                if (!rom_silent && rom_age >= rom_want) begin
                    bus.rom_valid = 1'b1;
                    bus.rom_data  = rom_byte(bus.rom_addr);
                    rom_age       = 0;
                end
            end else begin
                rom_age = 0;
            end
        end
    end

    // Monitor: every rdy pulse pops that client's expectation and compares.
    initial begin
        int   n;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                n = int'(bus.bg_rdy) + int'(bus.tx_rdy) + int'(bus.sp_rdy);
                if (n != 0) begin
                    chk("single_rdy", n, 1);
                    chk("rom_cs_low_at_rdy", {31'd0, bus.rom_cs}, 32'd0);
                end
                for (int id = 0; id < 3; id++) begin
                    if (get_rdy(id)) begin
                        rdy_cnt[id]++;
                        rdy_cyc[id] = cyc;
                        order_q.push_back(id);
                        case (id)
                            0:       n = exp_q0.size();
                            1:       n = exp_q1.size();
                            default: n = exp_q2.size();
                        endcase
                        if (n == 0) begin
                            chk("rdy_unexpected", id, 32'hFFFF_FFFF);
                        end else begin
                            case (id)
                                0:       e = exp_q0.pop_front();
                                1:       e = exp_q1.pop_front();
                                default: e = exp_q2.pop_front();
                            endcase
                            chk("client_data", {24'd0, get_data(id)}, {24'd0, e.data});
                        end
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, l0, l1, l2, a0, c0, found;
        int exp_order[5];
        exp_order = '{0, 1, 2, 0, 1};
        for (int i = 0; i < 3; i++) begin rdy_cnt[i] = 0; rdy_cyc[i] = 0; end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 17'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_rom_cs",   {31'd0, bus.rom_cs}, 32'd0);
        chk("rst_rom_addr", {10'd0, bus.rom_addr}, 32'd0);
        chk("rst_busy",     {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_rdy",  {31'd0, get_rdy(i)}, 32'd0);
            chk("rst_data", {24'd0, get_data(i)}, 32'd0);
        end

        // single bg fetch, ROM answering 3 cycles after rom_cs
        rom_delay_cfg = 3;
        a0 = acc_cnt;
        client_txn(0, 17'h00010, 1, lat);
        repeat (4) @(negedge clk);
        chk("t1_latency",  lat, 6);
        chk("t1_accesses", acc_cnt - a0, 1);
        chk("t1_rom_addr", {10'd0, acc_q[acc_q.size()-1]}, 32'h000010);
        chk("t1_rdy_once", rdy_cnt[0], 1);
        chk("t1_data_hold", {24'd0, bus.bg_data}, {24'd0, rom_byte(22'h000010)});
        chk("t1_busy_idle", {31'd0, bus.busy}, 32'd0);

        // all three requesting continuously: bg, tx, sp, bg, tx
        do_reset();
        rom_delay_cfg = 1;
        fork
            client_txn(0, 17'h00033, 2, l0);
            client_txn(1, 17'h00005, 2, l1);
            client_txn(2, 17'h01234, 1, l2);
        join
        repeat (8) @(negedge clk);
        chk("t2_order_len", order_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < order_q.size()) chk("t2_order", order_q[i], exp_order[i]);
        end
        found = 0;
        foreach (acc_q[i]) if (acc_q[i] == 22'h020005) found = 1;
        chk("t2_tx_rom_addr", found, 1);

        // sp held one cycle past rdy: single service
        do_reset();
        a0 = acc_cnt;
        c0 = rdy_cnt[2];
        client_txn(2, 17'h00ABC, 1, lat);
        repeat (10) @(negedge clk);
        chk("t3_accesses", acc_cnt - a0, 1);
        chk("t3_sp_rdy",   rdy_cnt[2] - c0, 1);

        // reset during WAIT, late rom_valid afterwards
        do_reset();
        rom_silent = 1'b1;
        begin
            exp_t e;
            e.addr = full_addr(2, 17'h00100);
            e.data = rom_byte(e.addr);
            push_exp(2, e);
        end
        set_req(2, 1'b1, 17'h00100);
        for (int t = 0; t < 20 && !bus.rom_cs; t++) @(negedge clk);
        chk("t4_cs_seen", {31'd0, bus.rom_cs}, 32'd1);
        @(negedge clk);
        c0 = rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2];
        reset = 1'b1;
        set_req(2, 1'b0, 17'h00100);
        @(negedge clk);
        reset = 1'b0;
        exp_q2.delete();
        rom_silent  = 1'b0;
        force_valid = 1'b1;
        repeat (6) @(negedge clk);
        chk("t4_no_rdy", rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] - c0, 0);
        chk("t4_busy",   {31'd0, bus.busy}, 32'd0);
        chk("t4_rom_cs", {31'd0, bus.rom_cs}, 32'd0);
        for (int i = 0; i < 3; i++) chk("t4_data", {24'd0, get_data(i)}, 32'd0);

        // same sp address twice
        do_reset();
        rom_delay_cfg = 2;
        a0 = acc_cnt;
        c0 = rdy_cnt[2];
        client_txn(2, 17'h00777, 1, l1);
        repeat (6) @(negedge clk);
        client_txn(2, 17'h00777, 1, l2);
        repeat (6) @(negedge clk);
        chk("t5_sp_rdy", rdy_cnt[2] - c0, 2);
        chk("t5_first_latency", l1, 5);
`ifdef GFX_ARB_CACHE_EN
        chk("t5_accesses", acc_cnt - a0, 1);
        chk("t5_hit_latency", l2, 2);
`else
        chk("t5_accesses", acc_cnt - a0, 2);
        chk("t5_second_latency", l2, 5);
`endif

        // randomized concurrent traffic
        do_reset();
        rom_delay_cfg = 0;
        fork
            rand_client(0, 25);
            rand_client(1, 25);
            rand_client(2, 25);
        join
        repeat (10) @(negedge clk);
        chk("rand_q0_empty", exp_q0.size(), 0);
        chk("rand_q1_empty", exp_q1.size(), 0);
        chk("rand_q2_empty", exp_q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
